// File: rtl/bnn_input_binarizer.sv
// bnn_input_binarizer: thresholds streamed pixels into a packed binary frame for the BNN input layer
module bnn_input_binarizer #(
  parameter int INPUT_SIZE  = 784,
  parameter int PIXEL_WIDTH = 8,
  parameter int IDX_WIDTH   = $clog2(INPUT_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIXEL_WIDTH-1:0] pix_threshold,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INPUT_SIZE-1:0]  out_vec,
  output logic                   frame_err
);
  typedef enum logic [1:0] {FILL, DISCARD, HOLD} state_t;
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(INPUT_SIZE - 1);
  state_t                state, state_n;
  logic [IDX_WIDTH-1:0]  idx, idx_n;
  logic [INPUT_SIZE-1:0] vec_n;
  logic                  err_n, acc;
  assign in_ready  = !rst && state != HOLD;
  assign out_valid = state == HOLD;
  assign acc       = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      out_vec   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      out_vec   <= vec_n;
      frame_err <= err_n;
    end
  end
  always_comb begin
    state_n = state;
    idx_n   = idx;
    vec_n   = out_vec;
    err_n   = frame_err;
    case (state)
      FILL: if (acc) begin
        vec_n[idx] = in_pixel >= pix_threshold;
        if (in_last) begin
          state_n = HOLD;
          err_n   = idx != LAST;
        end else if (idx == LAST) state_n = DISCARD;
        else idx_n = idx + 1'b1;
      end
      DISCARD: if (acc) begin
        err_n   = 1'b1;
        state_n = in_last ? HOLD : DISCARD;
      end
      default: if (out_ready) begin
        state_n = FILL;
        idx_n   = '0;
        vec_n   = '0;
        err_n   = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_bnn_input_binarizer.sv
// tb_bnn_input_binarizer: table-driven frames with a scoreboard checked at each output handshake
module tb_bnn_input_binarizer;
  localparam int N = 16, PW = 8, MAXB = 20;
  typedef logic [MAXB-1:0][PW-1:0] beats_t;
  typedef struct {
    int           len;
    logic [PW-1:0] thr;
    beats_t       pix;
    logic [N-1:0] vec;
    logic         err;
  } vec_t;
  typedef struct packed {
    logic [N-1:0] vec;
    logic         err;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [PW-1:0] pix_threshold = '0, in_pixel = '0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, frame_err;
  logic [N-1:0] out_vec;
  int n_checks = 0, n_fail = 0, n_rise = 0;
  exp_t sb[$];
  vec_t tbl[6];
  bnn_input_binarizer #(.INPUT_SIZE(N), .PIXEL_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .pix_threshold(pix_threshold), .in_valid(in_valid),
    .in_ready(in_ready), .in_pixel(in_pixel), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_vec(out_vec), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int len, input int last_i, input beats_t pix, input beats_t thr,
                      input bit stall, output int waits);
    bit acc;
    int guard;
    waits = 0;
    for (int i = 0; i < len; i++) begin
      if (stall && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_pixel = pix[i];
      pix_threshold = thr[i];
      in_last = i == last_i;
      acc = 1'b0;
      guard = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        tick();
        if (!acc) waits++;
        if (++guard > 50) begin
          $display("FAIL beat_timeout: beat %0d never accepted", i);
          $fatal(1, "timeout");
        end
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  logic [N-1:0] prev_vec;
  logic prev_err, prev_hold = 1'b0, prev_valid = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", in_ready, 0);
      prev_hold = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        check("hold_in_ready", in_ready, 0);
        if (prev_hold) check("hold_stable", {out_vec, frame_err}, {prev_vec, prev_err});
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_vec", out_vec, e.vec);
          check("frame_err", frame_err, e.err);
        end
      end
      if (out_valid && !prev_valid) n_rise++;
      prev_valid = out_valid;
      prev_hold = out_valid && !out_ready;
      prev_vec = out_vec;
      prev_err = frame_err;
    end
  end
  initial begin
    beats_t thr, pix;
    int waits, snap;
    for (int i = 0; i < MAXB; i++) begin
      tbl[0].pix[i] = (i % 4 == 0) ? 8'd0 : (i % 4 == 1) ? 8'd127 : (i % 4 == 2) ? 8'd128 : 8'd255;
      tbl[1].pix[i] = PW'(i * 7);
      tbl[2].pix[i] = 8'd0;
      tbl[3].pix[i] = PW'(i * 17);
      tbl[4].pix[i] = PW'(i % 2);
      tbl[5].pix[i] = 8'd200;
    end
    tbl[0].len = 16; tbl[0].thr = 8'd128; tbl[0].vec = 16'hCCCC; tbl[0].err = 1'b0;
    tbl[1].len = 10; tbl[1].thr = 8'd0;   tbl[1].vec = 16'h03FF; tbl[1].err = 1'b1;
    tbl[2].len = 20; tbl[2].thr = 8'd0;   tbl[2].vec = 16'hFFFF; tbl[2].err = 1'b1;
    tbl[3].len = 16; tbl[3].thr = 8'd255; tbl[3].vec = 16'h8000; tbl[3].err = 1'b0;
    tbl[4].len = 16; tbl[4].thr = 8'd1;   tbl[4].vec = 16'hAAAA; tbl[4].err = 1'b0;
    tbl[5].len = 1;  tbl[5].thr = 8'd100; tbl[5].vec = 16'h0001; tbl[5].err = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_vec", out_vec, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_in_ready", in_ready, 1);
    tick();
    foreach (tbl[k]) begin
      for (int i = 0; i < MAXB; i++) thr[i] = tbl[k].thr;
      sb.push_back('{tbl[k].vec, tbl[k].err});
      send(tbl[k].len, tbl[k].len - 1, tbl[k].pix, thr, k % 2 == 1, waits);
      check("no_wait_beats", waits, 0);
      @(negedge clk);
      check("valid_after_last", out_valid, 1);
      check("ready_low_in_hold", in_ready, 0);
      tick();
      @(negedge clk);
      check("valid_one_cycle", out_valid, 0);
      check("ready_after_hold", in_ready, 1);
      tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < MAXB; i++) thr[i] = 8'd128;
    sb.push_back('{16'hCCCC, 1'b0});
    send(16, 15, tbl[0].pix, thr, 1'b1, waits);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_vec", out_vec, 16'hCCCC);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < MAXB; i++) thr[i] = 8'd1;
    sb.push_back('{16'hAAAA, 1'b0});
    send(16, 15, tbl[4].pix, thr, 1'b0, waits);
    check("bp_next_start", waits, 1);
    repeat (2) tick();
    snap = n_rise;
    for (int i = 0; i < MAXB; i++) begin
      pix[i] = 8'd100;
      thr[i] = i < 8 ? 8'd100 : 8'd101;
    end
    send(7, -1, pix, thr, 1'b0, waits);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.push_back('{16'h00FF, 1'b0});
    send(16, 15, pix, thr, 1'b0, waits);
    repeat (3) tick();
    check("midrst_one_valid", n_rise - snap, 1);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bnn_input_binarizer.md
# bnn_input_binarizer

Streaming front end for the binary MLP. Accepts unsigned grayscale pixels one per cycle over a valid/ready handshake and binarizes each pixel against a programmable threshold. Packs the bits into an INPUT_SIZE-bit vector and presents the completed frame, held stable under a valid/ready handshake, to the neuron layer's binary input. It produces the vector that every neuron XNORs against its weights.

## Interface
- INPUT_SIZE, 784: pixels per frame and output vector width.
- PIXEL_WIDTH, 8: bits per input pixel, unsigned.
- IDX_WIDTH, $clog2(INPUT_SIZE): width of the internal pixel index.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- pix_threshold  input  PIXEL_WIDTH  binarization threshold, sampled on every accepted beat.
- in_valid  input  1  in_pixel and in_last are valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_pixel  input  PIXEL_WIDTH  pixel value.
- in_last  input  1  marks the final pixel of a frame.
- out_valid  output  1  out_vec and frame_err hold a complete frame.
- out_ready  input  1  consumer takes the frame.
- out_vec  output  INPUT_SIZE  binarized frame; pixel k of the frame maps to out_vec[k].
- frame_err  output  1  frame length was not INPUT_SIZE; valid while out_valid=1.

## Operation
- The bit for each pixel is (in_pixel >= pix_threshold), an unsigned compare. A threshold of 0 makes every bit 1.
- A beat is accepted when in_valid && in_ready.
- States are FILL, DISCARD and HOLD. Reset enters FILL with idx=0, out_vec=0, frame_err=0 and out_valid=0.
- FILL: in_ready=1. Each accepted beat writes its bit to out_vec[idx].
  - If in_last=1: go to HOLD. frame_err = (idx != INPUT_SIZE-1).
  - Else if idx == INPUT_SIZE-1: go to DISCARD.
  - Else: idx increments.
- DISCARD (frame over-length): in_ready=1.
  - Accepted beats are dropped and set frame_err=1.
  - An accepted beat with in_last=1 goes to HOLD.
  - out_vec keeps the first INPUT_SIZE bits.
- HOLD: in_ready=0 and out_valid=1. out_vec and frame_err are stable.
  - When out_ready=1: go to FILL with idx=0, out_vec=0 and frame_err=0.
- Short frame: bits at and above the index after the last pixel stay 0, and frame_err=1.
- An exact-length frame with in_last on beat INPUT_SIZE-1 gives frame_err=0 and never enters DISCARD.
- in_valid=0 stalls: state, idx and out_vec are unchanged.
- Beats with in_valid=1 while in_ready=0 are ignored. The producer holds them per standard valid/ready rules.

## Timing
- Reset cycle (rst=1 at an edge):
  - On the following cycle all registers hold reset values and the state is FILL.
  - in_ready is forced 0 while rst=1 and is 1 from the first cycle after rst deasserts.
- rst mid-frame or in HOLD discards the partial or held frame with no output pulse.
- out_valid rises the cycle after the beat carrying in_last is accepted.
- Frame handoff: out_valid falls and in_ready rises in the cycle after the out_valid && out_ready handshake.
- Maximum throughput is one frame per INPUT_SIZE+1 cycles, with in_valid and out_ready held at 1.
- All outputs are registered or decoded from the state register only. There is no combinational path from in_* or out_ready to any output.
- pix_threshold may change between beats and takes effect on the next accepted beat.

## Test plan
- Reset: rst=1 for 2 cycles, then 0 -> out_valid=0, out_vec=0, frame_err=0; in_ready=0 during reset and 1 after.
- Exact frame (INPUT_SIZE=16, threshold=128):
  - Stimulus: pixels 0,127,128,255 repeated, in_last on beat 15, out_ready=1.
  - Required: out_vec=16'hCCCC and frame_err=0.
  - out_valid is high for exactly 1 cycle, starting the cycle after beat 15.
  - in_ready is low in that same cycle.
- Backpressure and stalls (INPUT_SIZE=16):
  - Drop in_valid on random cycles; hold out_ready=0 for 5 cycles after out_valid.
  - Required: out_vec is stable and in_ready=0 throughout HOLD; the next frame starts the cycle after out_ready=1.
- Short frame (INPUT_SIZE=16, threshold=0):
  - 10 pixels with in_last on beat 9 -> out_vec=16'h03FF, frame_err=1.
- Long frame (INPUT_SIZE=16, threshold=0):
  - 20 beats with in_last on beat 19 -> out_vec=16'hFFFF, frame_err=1.
  - in_ready stays 1 through beats 16-19.
- Mid-frame reset and threshold change (INPUT_SIZE=16):
  - Assert rst after 7 beats; send a fresh exact frame of all 100s.
  - Use threshold=100 for beats 0-7 and threshold=101 for beats 8-15.
  - Required: exactly one out_valid, with out_vec=16'h00FF and frame_err=0.
